// File: rtl/traffic_pkg.sv
// Shared phase/state encodings for the intersection phase scheduler.
package traffic_pkg;

  localparam int NUM_PHASES = 4;

  typedef enum logic [1:0] {
    PH_PED  = 2'd0,
    PH_UP   = 2'd1,
    PH_DOWN = 2'd2,
    PH_TURN = 2'd3
  } phase_e;

  typedef enum logic [1:0] {
    IDLE,
    GREEN,
    AMBER,
    CLEAR
  } sched_state_e;

  function automatic logic [NUM_PHASES-1:0] phase_onehot(input phase_e p);
    logic [NUM_PHASES-1:0] v;
    v    = '0;
    v[p] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/phase_scheduler_if.sv
// Request inputs and signal-head outputs of the phase scheduler.
interface phase_scheduler_if;
  import traffic_pkg::*;

  logic            ped_req;
  logic            up_req;
  logic            down_req;
  logic            turn_req;
  logic            pedestrian_green;
  logic            up_green;
  logic            down_green;
  logic            turn_green;
  logic            amber;
  logic            all_red;
  phase_e          phase;
  logic [3:0]      pending;

  // master: the scheduler driving the signal heads
  modport master (
    input  ped_req, up_req, down_req, turn_req,
    output pedestrian_green, up_green, down_green, turn_green,
    output amber, all_red, phase, pending
  );

  // slave: the intersection raising requests and consuming the heads
  modport slave (
    output ped_req, up_req, down_req, turn_req,
    input  pedestrian_green, up_green, down_green, turn_green,
    input  amber, all_red, phase, pending
  );

endinterface

// File: rtl/rr_pick.sv
// Combinational 4-way round-robin picker: first set pending bit at or after start.
module rr_pick
  import traffic_pkg::*;
(
  input  logic [NUM_PHASES-1:0] pending,
  input  phase_e                start,
  output logic                  valid,
  output phase_e                index
);

  logic [2*NUM_PHASES-1:0] dbl;
  logic [NUM_PHASES-1:0]   rot;
  logic [1:0]              offset;

  // Rotating a doubled copy puts the start phase at bit 0.
  assign dbl = {pending, pending};
  assign rot = NUM_PHASES'(dbl >> start);

  always_comb begin
    valid  = |rot;
    offset = 2'd0;
    for (int k = NUM_PHASES - 1; k >= 0; k--) begin
      if (rot[k]) offset = 2'(k);
    end
    index = phase_e'(start + offset);
  end

endmodule

// File: rtl/phase_scheduler.sv
// Four-phase signal scheduler: latched requests, round-robin grants,
// minimum green, amber and all-red clearance between phases.
module phase_scheduler
  import traffic_pkg::*;
#(
  parameter int GREEN_MIN    = 8,
  parameter int AMBER_CYCLES = 3,
  parameter int CLEAR_CYCLES = 2,
  parameter int CNT_W        = 8
) (
  input  logic               clock,
  input  logic               reset,
  phase_scheduler_if.master  bus
);

  localparam logic [CNT_W-1:0] GREEN_TC = CNT_W'(GREEN_MIN - 1);
  localparam logic [CNT_W-1:0] AMBER_TC = CNT_W'(AMBER_CYCLES - 1);
  localparam logic [CNT_W-1:0] CLEAR_TC = CNT_W'(CLEAR_CYCLES - 1);

  sched_state_e          state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [NUM_PHASES-1:0] pending_q, pending_d;
  phase_e                last_q, last_d;
  phase_e                rr_q, rr_d;
  logic [NUM_PHASES-1:0] greens_q, greens_d;
  logic                  amber_q, amber_d;
  logic                  all_red_q, all_red_d;

  logic [NUM_PHASES-1:0] req;
  logic                  pick_valid;
  phase_e                pick_idx;
  logic                  grant;
  logic                  others_waiting;

  assign req = {bus.turn_req, bus.down_req, bus.up_req, bus.ped_req};

  rr_pick u_pick (
    .pending (pending_q),
    .start   (rr_q),
    .valid   (pick_valid),
    .index   (pick_idx)
  );

  always_comb begin
    // NOTE: every variable gets a default before the case so no path infers a latch.
    state_d        = state_q;
    cnt_d          = cnt_q;
    last_d         = last_q;
    rr_d           = rr_q;
    grant          = 1'b0;
    others_waiting = |(pending_q & ~phase_onehot(last_q));
    pending_d      = pending_q | req;

    unique case (state_q)
      IDLE: begin
        grant = pick_valid;
      end
      GREEN: begin
        // Re-requests for the phase already showing green are dropped.
        pending_d = pending_q | (req & ~phase_onehot(last_q));
        if (cnt_q >= GREEN_TC && others_waiting) begin
          state_d = AMBER;
          cnt_d   = '0;
        end else if (cnt_q != GREEN_TC) begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      AMBER: begin
        if (cnt_q == AMBER_TC) begin
          state_d = CLEAR;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      CLEAR: begin
        if (cnt_q == CLEAR_TC) begin
          grant   = pick_valid;
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    if (grant) begin
      state_d             = GREEN;
      cnt_d               = '0;
      last_d              = pick_idx;
      rr_d                = phase_e'(pick_idx + 2'd1);
      pending_d[pick_idx] = 1'b0;
    end

    // Outputs are decoded from the next state so they leave a register.
    greens_d  = (state_d == GREEN) ? phase_onehot(last_d) : '0;
    amber_d   = (state_d == AMBER);
    all_red_d = (state_d == IDLE) || (state_d == CLEAR);
  end

  always_ff @(posedge clock) begin
    // NOTE: non-blocking assignments so every register samples pre-edge values.
    if (reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      pending_q <= '0;
      last_q    <= PH_PED;
      rr_q      <= PH_PED;
      greens_q  <= '0;
      amber_q   <= 1'b0;
      all_red_q <= 1'b1;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      pending_q <= pending_d;
      last_q    <= last_d;
      rr_q      <= rr_d;
      greens_q  <= greens_d;
      amber_q   <= amber_d;
      all_red_q <= all_red_d;
    end
  end

  assign bus.pedestrian_green = greens_q[PH_PED];
  assign bus.up_green         = greens_q[PH_UP];
  assign bus.down_green       = greens_q[PH_DOWN];
  assign bus.turn_green       = greens_q[PH_TURN];
  assign bus.amber            = amber_q;
  assign bus.all_red          = all_red_q;
  assign bus.phase            = last_q;
  assign bus.pending          = pending_q;

endmodule

// File: tb/tb_phase_scheduler.sv
// Bench for phase_scheduler: vector table, directed corner sequences and
// randomized requests against a cycle-level reference model.
module tb_phase_scheduler;
  import traffic_pkg::*;

  localparam int GREEN_MIN    = 8;
  localparam int AMBER_CYCLES = 3;
  localparam int CLEAR_CYCLES = 2;
  localparam int WAIT_BOUND   = 4 * (GREEN_MIN + AMBER_CYCLES + CLEAR_CYCLES) + 2;

  logic clock = 1'b0;
  logic reset = 1'b1;

  phase_scheduler_if bus();

  phase_scheduler #(
    .GREEN_MIN    (GREEN_MIN),
    .AMBER_CYCLES (AMBER_CYCLES),
    .CLEAR_CYCLES (CLEAR_CYCLES),
    .CNT_W        (8)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  int n_vec = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Observation word: {greens[3:0] (bit = phase), amber, all_red, phase[1:0], pending[3:0]}
  function automatic logic [11:0] dut_obs();
    return {bus.turn_green, bus.down_green, bus.up_green, bus.pedestrian_green,
            bus.amber, bus.all_red, 2'(bus.phase), bus.pending};
  endfunction

  // Reference model: which phase holds green and for how long, plus how many
  // amber/all-red cycles remain before the next grant decision.
  bit m_pend [4];
  bit m_on;
  int m_last, m_age, m_gap, m_rr;
  int m_wait [4];
  bit m_granted;
  int m_grant_wait;

  task automatic model_reset();
    for (int i = 0; i < 4; i++) begin
      m_pend[i] = 1'b0;
      m_wait[i] = 0;
    end
    m_on = 1'b0; m_last = 0; m_age = 0; m_gap = 0; m_rr = 0;
    m_granted = 1'b0; m_grant_wait = 0;
  endtask

  task automatic model_step(input logic [3:0] r);
    bit nxt [4];
    bit decide;
    bit others;
    int p;
    m_granted = 1'b0;
    for (int i = 0; i < 4; i++)
      nxt[i] = m_pend[i] | (r[i] && !(m_on && i == m_last));
    decide = 1'b0;
    if (m_on) begin
      others = 1'b0;
      for (int j = 0; j < 4; j++)
        if (j != m_last && m_pend[j]) others = 1'b1;
      if (m_age >= GREEN_MIN && others) begin
        m_on  = 1'b0;
        m_gap = AMBER_CYCLES + CLEAR_CYCLES;
      end else begin
        m_age++;
      end
    end else if (m_gap > 1) begin
      m_gap--;
    end else begin
      decide = 1'b1;
    end
    if (decide) begin
      m_gap = 0;
      for (int k = 0; k < 4; k++) begin
        p = (m_rr + k) % 4;
        if (m_pend[p]) begin
          m_on = 1'b1; m_age = 1; m_last = p; m_rr = (p + 1) % 4;
          nxt[p] = 1'b0;
          m_granted = 1'b1;
          m_grant_wait = m_wait[p] + 1;
          break;
        end
      end
    end
    for (int i = 0; i < 4; i++) begin
      m_wait[i] = nxt[i] ? m_wait[i] + 1 : 0;
      m_pend[i] = nxt[i];
    end
  endtask

  function automatic logic [11:0] model_obs();
    logic [3:0] g;
    logic [3:0] pd;
    g = '0;
    if (m_on) g[m_last] = 1'b1;
    for (int i = 0; i < 4; i++) pd[i] = m_pend[i];
    return {g, !m_on && (m_gap > CLEAR_CYCLES), !m_on && (m_gap <= CLEAR_CYCLES), 2'(m_last), pd};
  endfunction

  task automatic step(input logic rst, input logic [3:0] r);
    reset = rst;
    {bus.turn_req, bus.down_req, bus.up_req, bus.ped_req} = r;
    @(posedge clock);
    if (rst) model_reset();
    else     model_step(r);
    @(negedge clock);
  endtask

  task automatic step_chk(input logic rst, input logic [3:0] r, input string name);
    step(rst, r);
    check(name, 32'(dut_obs()), 32'(model_obs()));
  endtask

  typedef struct {
    logic       rst;
    logic [3:0] req;
    int         n;
    logic [3:0] greens;
    logic       amber;
    logic       all_red;
    logic [1:0] phase;
    logic [3:0] pend;
  } vec_t;

  vec_t tbl [$];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] g, gp;
    int         order [$];
    int         gcnt [4];
    int         found;
    int         up_seen;

    bus.ped_req = 1'b0; bus.up_req = 1'b0; bus.down_req = 1'b0; bus.turn_req = 1'b0;
    model_reset();
    @(negedge clock);

    // ---- table: ped pulse, exact 8-cycle green when up arrives, amber, clear, up green
    //                 rst   req     n   greens  amb   ared  ph     pend
    tbl.push_back('{1'b1, 4'h0,  2, 4'h0, 1'b0, 1'b1, 2'd0, 4'h0});
    tbl.push_back('{1'b0, 4'h0,  1, 4'h0, 1'b0, 1'b1, 2'd0, 4'h0});
    tbl.push_back('{1'b0, 4'h1,  1, 4'h0, 1'b0, 1'b1, 2'd0, 4'h1});
    tbl.push_back('{1'b0, 4'h0,  1, 4'h1, 1'b0, 1'b0, 2'd0, 4'h0});
    tbl.push_back('{1'b0, 4'h0,  2, 4'h1, 1'b0, 1'b0, 2'd0, 4'h0});
    tbl.push_back('{1'b0, 4'h2,  1, 4'h1, 1'b0, 1'b0, 2'd0, 4'h2});
    tbl.push_back('{1'b0, 4'h0,  4, 4'h1, 1'b0, 1'b0, 2'd0, 4'h2});
    tbl.push_back('{1'b0, 4'h0,  3, 4'h0, 1'b1, 1'b0, 2'd0, 4'h2});
    tbl.push_back('{1'b0, 4'h0,  2, 4'h0, 1'b0, 1'b1, 2'd0, 4'h2});
    tbl.push_back('{1'b0, 4'h0, 16, 4'h2, 1'b0, 1'b0, 2'd1, 4'h0});

    for (int v = 0; v < tbl.size(); v++) begin
      for (int c = 0; c < tbl[v].n; c++) begin
        step(tbl[v].rst, tbl[v].req);
        check($sformatf("vec%0d.%0d", v, c), 32'(dut_obs()),
              32'({tbl[v].greens, tbl[v].amber, tbl[v].all_red, tbl[v].phase, tbl[v].pend}));
      end
    end

    // ---- all four requests in one cycle from IDLE: served ped, up, down, turn
    step_chk(1'b1, 4'h0, "seqA_rst");
    step_chk(1'b0, 4'h0, "seqA_idle");
    step_chk(1'b0, 4'hF, "seqA_req");
    check("seqA_latched", 32'(bus.pending), 32'hF);
    gp = '0;
    for (int i = 0; i < 4; i++) gcnt[i] = 0;
    for (int c = 0; c < 70; c++) begin
      step_chk(1'b0, 4'h0, "seqA_model");
      g = dut_obs()[11:8];
      if (g != 4'h0 && g != gp) order.push_back(int'(bus.phase));
      for (int i = 0; i < 4; i++) if (g[i]) gcnt[i]++;
      gp = g;
    end
    check("seqA_grants", 32'(order.size()), 32'd4);
    for (int i = 0; i < 4; i++)
      check($sformatf("seqA_order%0d", i), 32'(i < order.size() ? order[i] : 99), 32'(i));
    for (int i = 0; i < 3; i++)
      check($sformatf("seqA_len%0d", i), 32'(gcnt[i]), 32'(GREEN_MIN));

    // ---- up re-requested during its own green while turn waits: turn next
    step_chk(1'b1, 4'h0, "seqB_rst");
    step_chk(1'b0, 4'h2, "seqB_up");
    step_chk(1'b0, 4'h0, "seqB_green");
    check("seqB_up_green", 32'(bus.up_green), 32'd1);
    step_chk(1'b0, 4'h8, "seqB_turn");
    step_chk(1'b0, 4'h2, "seqB_uprepeat");
    check("seqB_up_dropped", 32'(bus.pending[1]), 32'd0);
    found = 99;
    gp = dut_obs()[11:8];
    for (int c = 0; c < 40 && found == 99; c++) begin
      step_chk(1'b0, 4'h0, "seqB_model");
      g = dut_obs()[11:8];
      if (g != 4'h0 && g != gp) found = int'(bus.phase);
      gp = g;
    end
    check("seqB_next", 32'(found), 32'd3);
    up_seen = 0;
    for (int c = 0; c < 30; c++) begin
      step_chk(1'b0, 4'h0, "seqB_rest");
      if (bus.up_green) up_seen++;
    end
    check("seqB_no_up", 32'(up_seen), 32'd0);

    // ---- reset during amber with down pending
    step_chk(1'b1, 4'h0, "seqC_rst");
    step_chk(1'b0, 4'h1, "seqC_ped");
    step_chk(1'b0, 4'h4, "seqC_down");
    found = 0;
    for (int c = 0; c < 30 && found == 0; c++) begin
      step_chk(1'b0, 4'h0, "seqC_model");
      if (bus.amber) found = 1;
    end
    check("seqC_amber_reached", 32'(found), 32'd1);
    step(1'b1, 4'h0);
    check("seqC_after_reset", 32'(dut_obs()), 32'h040);
    up_seen = 0;
    for (int c = 0; c < 20; c++) begin
      step_chk(1'b0, 4'h0, "seqC_quiet");
      if (dut_obs()[11:8] != 4'h0) up_seen++;
    end
    check("seqC_no_green", 32'(up_seen), 32'd0);

    // ---- random requests against the model
    for (int c = 0; c < 10000; c++) begin
      logic [3:0] r;
      logic       rs;
      for (int i = 0; i < 4; i++) r[i] = ($urandom_range(0, 15) == 0);
      rs = ($urandom_range(0, 1999) == 0);
      step_chk(rs, r, "rand_model");
      g = dut_obs()[11:8];
      check("rand_onehot", 32'($countones(g) <= 1), 32'd1);
      check("rand_amber_excl", 32'(bus.amber && (g != 4'h0)), 32'd0);
      if (m_granted)
        check("rand_latency", 32'(m_grant_wait <= WAIT_BOUND), 32'd1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
